// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared state encoding and header constants for the image loader
package core_pkg;

  localparam int HDR_W = 16;

  typedef enum logic [2:0] {
    CNT_LO = 3'd0,
    CNT_HI = 3'd1,
    DATA   = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } load_state_t;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader that writes a length-prefixed image into instruction memory
module imem_loader
  import core_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error
);

  localparam logic [31:0]   MAX_WORDS = 32'd1 << ADDR_W;
  localparam logic [ADDR_W:0] WIDX_ONE = 1;

  load_state_t       state_q, state_d;
  logic [HDR_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W:0]   widx_q, widx_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [23:0]       buf_q, buf_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [HDR_W-1:0]  hdr_n;
  logic              xfer;

  assign rx_ready  = (state_q == CNT_LO) || (state_q == CNT_HI) || (state_q == DATA);
  assign xfer      = rx_valid && rx_ready;
  assign hdr_n     = {rx_data, cnt_q[7:0]};
  assign mem_we    = (state_q == WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign core_hold = (state_q != DONE);
  assign done      = (state_q == DONE);
  assign error     = (state_q == ERR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    buf_d   = buf_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      CNT_LO: begin
        if (xfer) begin
          cnt_d[7:0] = rx_data;
          state_d    = CNT_HI;
        end
      end
      CNT_HI: begin
        if (xfer) begin
          cnt_d  = hdr_n;
          widx_d = '0;
          bidx_d = '0;
          if (hdr_n == '0 || 32'(hdr_n) > MAX_WORDS) state_d = ERR;
          else                                       state_d = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          bidx_d = bidx_q + 2'd1;
          case (bidx_q)
            2'd0: buf_d[7:0]   = rx_data;
            2'd1: buf_d[15:8]  = rx_data;
            2'd2: buf_d[23:16] = rx_data;
            default: begin
              // Latch address and word together so the memory port stays stable after the strobe.
              addr_d  = widx_q[ADDR_W-1:0];
              wdata_d = {rx_data, buf_q};
              state_d = WRITE;
            end
          endcase
        end
      end
      WRITE: begin
        widx_d = widx_q + WIDX_ONE;
        if (32'(widx_q) + 32'd1 == 32'(cnt_q)) state_d = DONE;
        else                                   state_d = DATA;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CNT_LO;
      cnt_q   <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader with a stream-level reference model
module tb_imem_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_hold;
  logic              done;
  logic              error;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t exp_q[$];
  int  n_pass  = 0;
  int  n_total = 0;
  int  cyc     = 0;
  bit  exp_done, exp_err;
  bit  prev_xfer = 1'b0;
  bit  prev_we   = 1'b0;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: the expected writes follow directly from the byte stream's layout.
  task automatic model(input bq_t b);
    int n, words;
    wr_t w;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (b.size() < 2) return;
    n = int'(b[0]) + 256 * int'(b[1]);
    if (n == 0 || n > (1 << ADDR_W)) begin
      exp_err = 1'b1;
      return;
    end
    words = (b.size() - 2) / 4;
    if (words > n) words = n;
    for (int k = 0; k < words; k++) begin
      w.addr = ADDR_W'(k);
      w.data = {b[5+4*k], b[4+4*k], b[3+4*k], b[2+4*k]};
      exp_q.push_back(w);
    end
    exp_done = (words == n);
  endtask

  always @(negedge clk) begin
    wr_t w;
    if (mem_we) begin
      chk("we_latency", 64'(prev_xfer), 64'd1);
      chk("we_single_cycle", 64'(prev_we), 64'd0);
      chk("we_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        chk("mem_addr", 64'(mem_addr), 64'(w.addr));
        chk("mem_wdata", 64'(mem_wdata), 64'(w.data));
      end
    end
    prev_xfer = rx_valid && rx_ready && !reset;
    prev_we   = mem_we;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int g;
    if (gap > 0) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      repeat (gap) @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    g = 0;
    while (!rx_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!rx_ready) chk("rx_ready_timeout", 64'(rx_ready), 64'd1);
    @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_done"}, 64'(done), 64'(exp_done));
    chk({tag, "_error"}, 64'(error), 64'(exp_err));
    chk({tag, "_core_hold"}, 64'(core_hold), 64'(!exp_done));
    chk({tag, "_rx_ready"}, 64'(rx_ready), 64'(!(exp_done || exp_err)));
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    chk("rst_rx_ready", 64'(rx_ready), 64'd1);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_core_hold", 64'(core_hold), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    reset = 1'b0;
    exp_q.delete();
  endtask

  // mode 0: rx_valid held high, 1: toggled every other cycle, 2: random gaps
  task automatic run_load(input string tag, input bq_t b, input int mode, input bit timed);
    int c0, g, gap;
    model(b);
    c0 = cyc;
    for (int i = 0; i < b.size(); i++) begin
      gap = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
      send_byte(b[i], gap);
    end
    rx_valid = 1'b0;
    g = 0;
    while (!(done || error) && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (timed) chk({tag, "_cycles"}, 64'(cyc - c0), 64'(2 + 5 * ((b.size() - 2) / 4)));
    check_status(tag);
    chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic hold_after_error(input string tag);
    rx_valid = 1'b1;
    repeat (4) begin
      rx_data = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    chk({tag, "_still_error"}, 64'(error), 64'd1);
    chk({tag, "_still_hold"}, 64'(core_hold), 64'd1);
  endtask

  initial begin
    bq_t ref_img, b;
    int  n;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    do_reset();

    ref_img = '{8'h02, 8'h00, 8'h93, 8'h80, 8'hA0, 8'h02, 8'h13, 8'hC1, 8'h50, 8'h03};
    run_load("ref_held", ref_img, 0, 1'b1);
    do_reset();
    run_load("ref_toggle", ref_img, 1, 1'b0);

    do_reset();
    run_load("hdr_zero", '{8'h00, 8'h00}, 0, 1'b0);
    hold_after_error("hdr_zero");
    do_reset();
    run_load("hdr_1025", '{8'h01, 8'h04}, 0, 1'b0);
    hold_after_error("hdr_1025");

    do_reset();
    b = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    model(b);
    for (int i = 0; i < b.size(); i++) send_byte(b[i], 0);
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h88;
    @(negedge clk);
    chk("midrst_no_we", 64'(mem_we), 64'd0);
    chk("midrst_addr", 64'(mem_addr), 64'd0);
    chk("midrst_wdata", 64'(mem_wdata), 64'd0);
    reset    = 1'b0;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_drained", 64'(exp_q.size()), 64'd0);
    chk("midrst_hold", 64'(core_hold), 64'd1);
    run_load("reload_n1", '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, 0, 1'b0);

    do_reset();
    b = '{8'h00, 8'h04};
    for (int k = 0; k < 1024; k++) begin
      b.push_back(8'(k));
      b.push_back(8'(k >> 8));
      b.push_back(8'h00);
      b.push_back(8'h00);
    end
    run_load("n1024", b, 0, 1'b1);
    chk("n1024_last_addr", 64'(mem_addr), 64'd1023);
    chk("n1024_last_data", 64'(mem_wdata), 64'd1023);

    for (int t = 0; t < 6; t++) begin
      do_reset();
      n = int'($urandom_range(1, 6));
      b = '{8'(n), 8'h00};
      for (int i = 0; i < 4 * n; i++) b.push_back(8'($urandom));
      run_load("rand_load", b, 2, 1'b0);
    end
    for (int t = 0; t < 3; t++) begin
      do_reset();
      n = (t == 0) ? 0 : int'($urandom_range(1025, 65535));
      run_load("rand_badhdr", '{8'(n), 8'(n >> 8)}, 2, 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
